// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
// master = requester (pipeline), slave = muldiv_unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             flush_i;
  logic             ready_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output valid_i, op_i, a_i, b_i, flush_i,
    input  ready_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  valid_i, op_i, a_i, b_i, flush_i,
    output ready_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: radix-2 shift-add multiply, radix-2 restoring divide, HI/LO result.
// Build option MULDIV_FAST_MUL_EN: multiplies finish after one BUSY cycle using a full-width multiplier.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  muldiv_unit_if.slave       bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               ready_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;

  logic               accept;
  logic               is_div;
  logic               is_signed;
  logic               last_step;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [2*WIDTH-1:0] prod_fin;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;
  logic               sign_diff;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic n);
    return n ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_if_wide(input logic [2*WIDTH-1:0] x, input logic n);
    return n ? (~x + 1'b1) : x;
  endfunction

  assign accept    = bus.valid_i && ready_r && !bus.flush_i;
  assign is_div    = op_r[1];
  assign is_signed = !op_r[0];

`ifdef MULDIV_FAST_MUL_EN
  assign last_step = !is_div || (cnt == CNT_LAST);
  assign prod_fin  = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`else
  assign last_step = (cnt == CNT_LAST);
  assign prod_fin  = prod_nxt;
`endif

  // One iteration: multiplier LSB-first into the accumulator, dividend MSB-first into the remainder.
  always_comb begin
    sum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag_a} : '0);
    prod_nxt = {sum, prod[WIDTH-1:1]};
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted[WIDTH-1:0] - mag_b;
    q_bit    = (shifted >= {1'b0, mag_b});
    rem_nxt  = q_bit ? diff : shifted[WIDTH-1:0];
    quo_nxt  = {quo[WIDTH-2:0], q_bit};
  end

  // Sign fix-up of the final iteration; divide-by-zero bypasses the datapath result.
  always_comb begin
    sign_diff = is_signed && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
    prod_fix  = neg_if_wide(prod_fin, sign_diff);
    res_hi    = prod_fix[2*WIDTH-1:WIDTH];
    res_lo    = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (b_r == '0) begin
        res_hi = a_r;
        res_lo = '1;
      end else begin
        res_hi = neg_if(rem_nxt, is_signed && a_r[WIDTH-1]);
        res_lo = neg_if(quo_nxt, sign_diff);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= BUSY;
            ready_r <= 1'b0;
            cnt     <= '0;
          end
        end
        BUSY: begin
          if (bus.flush_i) begin
            state   <= IDLE;
            ready_r <= 1'b1;
          end else if (last_step) begin
            state <= DONE;
            hi_r  <= res_hi;
            lo_r  <= res_lo;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          ready_r <= 1'b1;
          done_r  <= !bus.flush_i;
        end
        default: begin
          state   <= IDLE;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Operand and working registers carry no reset; they are always loaded at accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r  <= bus.op_i;
      a_r   <= bus.a_i;
      b_r   <= bus.b_i;
      mag_a <= mag_of(bus.a_i, !bus.op_i[0]);
      mag_b <= mag_of(bus.b_i, !bus.op_i[0]);
      prod  <= {{WIDTH{1'b0}}, mag_of(bus.b_i, !bus.op_i[0])};
      rem   <= '0;
      quo   <= mag_of(bus.a_i, !bus.op_i[0]);
    end else if (state == BUSY) begin
      prod <= prod_nxt;
      rem  <= rem_nxt;
      quo  <= quo_nxt;
    end
  end

  assign bus.ready_o = ready_r;
  assign bus.done_o  = done_r;
  assign bus.hi_o    = hi_r;
  assign bus.lo_o    = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, randomized ops against an arithmetic model,
// flush, valid+flush in IDLE, and mid-op reset.
module tb_muldiv_unit;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] prev_hi;
  logic [31:0] prev_lo;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (op)
      2'b00: begin
        p = sa * sb;
        res = p;
      end
      2'b01: res = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  function automatic int exp_latency(input logic [1:0] op);
`ifdef MULDIV_FAST_MUL_EN
    return op[1] ? 33 : 2;
`else
    return 33;
`endif
  endfunction

  task automatic wait_ready();
    int k;
    for (k = 0; k < 60 && !bus.ready_o; k++) begin
      @(posedge clk); #1;
    end
    if (!bus.ready_o) check_val("ready_timeout", 64'(bus.ready_o), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int lat, n;
    bit seen;
    exp = model(op, a, b);
    lat = exp_latency(op);
    wait_ready();
    bus.valid_i = 1'b1;
    bus.op_i = op;
    bus.a_i = a;
    bus.b_i = b;
    @(posedge clk); #1;
    bus.op_i = 2'($urandom);
    bus.a_i = $urandom;
    bus.b_i = $urandom;
    check_val({tag, "_busy_ready"}, 64'(bus.ready_o), 64'd0);
    seen = 1'b0;
    for (n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      if (lat > 12 && n == 10) check_val({tag, "_hold"}, {bus.hi_o, bus.lo_o}, {prev_hi, prev_lo});
      if (bus.done_o) begin
        seen = 1'b1;
        break;
      end
    end
    check_val({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check_val({tag, "_latency"}, 64'(n), 64'(lat));
      check_val({tag, "_hilo"}, {bus.hi_o, bus.lo_o}, exp);
      prev_hi = exp[63:32];
      prev_lo = exp[31:0];
      @(posedge clk); #1;
      check_val({tag, "_done_pulse"}, {63'd0, bus.done_o}, 64'd0);
      check_val({tag, "_ready_after"}, 64'(bus.ready_o), 64'd1);
    end
  endtask

  task automatic no_done_for(input string tag, input int cycles);
    int cnt;
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.done_o) cnt++;
    end
    check_val({tag, "_no_done"}, 64'(cnt), 64'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.op_i = 2'b00;
    bus.a_i = '0;
    bus.b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("rst_ready", 64'(bus.ready_o), 64'd1);
    check_val("rst_done", 64'(bus.done_o), 64'd0);
    check_val("rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    prev_hi = '0;
    prev_lo = '0;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_val("multu_max_const", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5);
    check_val("mult_neg_const", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
    check_val("div_neg_const", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_small", 2'b11, 32'd7, 32'd2);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    check_val("div_ovf_const", {bus.hi_o, bus.lo_o}, 64'h0000_0000_8000_0000);
    run_op("divu_zero", 2'b11, 32'h0000_1234, 32'd0);
    check_val("divu_zero_const", {bus.hi_o, bus.lo_o}, 64'h0000_1234_FFFF_FFFF);
    run_op("div_zero_neg", 2'b10, 32'hFFFF_FF00, 32'd0);
    run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000);

    for (int i = 0; i < 20; i++) begin
      op = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op("rand", op, a, b);
    end

    // Flush mid-op: result registers keep the last completed result.
    wait_ready();
    bus.valid_i = 1'b1;
    bus.op_i = 2'b01;
    bus.a_i = 32'd3;
    bus.b_i = 32'd4;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    check_val("flush_ready", 64'(bus.ready_o), 64'd1);
    check_val("flush_done", 64'(bus.done_o), 64'd0);
    check_val("flush_hilo", {bus.hi_o, bus.lo_o}, {prev_hi, prev_lo});
    no_done_for("flush", 40);
    check_val("flush_hilo_later", {bus.hi_o, bus.lo_o}, {prev_hi, prev_lo});

    // valid together with flush in IDLE must not be accepted.
    bus.valid_i = 1'b1;
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    check_val("vflush_ready", 64'(bus.ready_o), 64'd1);
    no_done_for("vflush", 40);

    // Reset during an op discards it.
    bus.valid_i = 1'b1;
    bus.op_i = 2'b11;
    bus.a_i = 32'd100;
    bus.b_i = 32'd7;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_val("midrst_ready", 64'(bus.ready_o), 64'd1);
    check_val("midrst_done", 64'(bus.done_o), 64'd0);
    check_val("midrst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    prev_hi = '0;
    prev_lo = '0;
    no_done_for("midrst", 40);

    run_op("post_rst", 2'b11, 32'd100, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
